// File: rtl/move_scheduler.sv
// Move scheduler: owns the single board write port, runs read-check-write for
// human and AI moves, kicks the win checker, and tracks turn and game-over state.
module move_scheduler #(
    parameter int AI_TIMEOUT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ai_en,
    input  logic       i_hum_valid,
    output logic       o_hum_ready,
    input  logic [1:0] i_hum_player,
    input  logic [1:0] i_hum_row,
    input  logic [1:0] i_hum_col,
    output logic       o_ai_start,
    input  logic       i_ai_done,
    input  logic [1:0] i_ai_row,
    input  logic [1:0] i_ai_col,
    output logic [3:0] o_brd_addr,
    input  logic [1:0] i_brd_rd_data,
    output logic       o_brd_we,
    output logic [1:0] o_brd_wdata,
    output logic       o_chk_start,
    input  logic       i_chk_done,
    input  logic [1:0] i_chk_win,
    output logic [1:0] o_turn,
    output logic       o_err,
    output logic [2:0] o_err_code,
    output logic       o_game_over,
    output logic [1:0] o_win
);

    typedef enum logic [2:0] {
        IDLE, READ, WRITE, CHK_START, CHK_WAIT, AI_START, AI_WAIT, OVER
    } state_t;

    localparam logic [1:0] P_X = 2'b01;
    localparam logic [1:0] P_O = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AI_TIMEOUT - 1);

    function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
        cell_idx = ({2'b00, row} * 4'd3) + {2'b00, col};
    endfunction

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_turn, w_turn_nxt, w_turn_tog;
    logic             r_o_ai, w_o_ai_nxt;
    logic             r_is_ai, w_is_ai_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_addr, w_addr_nxt;
    logic             w_err;
    logic [2:0]       r_err_code, w_err_code;
    logic             r_game_over, w_game_over_nxt;
    logic [1:0]       r_win, w_win_nxt;
    logic             r_hum_ready, r_ai_start, r_brd_we, r_chk_start, r_err;
    logic [1:0]       r_brd_wdata;
    logic             w_accept;

    assign w_accept   = i_hum_valid & r_hum_ready;
    assign w_turn_tog = (r_turn == P_X) ? P_O : P_X;

    // Next-state, move checking and error selection
    always_comb begin
        w_state_nxt     = r_state;
        w_turn_nxt      = r_turn;
        w_o_ai_nxt      = r_o_ai;
        w_is_ai_nxt     = r_is_ai;
        w_cnt_nxt       = r_cnt;
        w_addr_nxt      = r_addr;
        w_err           = 1'b0;
        w_err_code      = r_err_code;
        w_game_over_nxt = r_game_over;
        w_win_nxt       = r_win;
        case (r_state)
            IDLE: begin
                if (!w_accept) begin
                    w_state_nxt = IDLE;
                end else if (i_hum_row == 2'd3 || i_hum_col == 2'd3 ||
                             (i_hum_player != P_X && i_hum_player != P_O)) begin
                    w_err      = 1'b1;
                    w_err_code = 3'd1;
                end else if (i_hum_player != r_turn) begin
                    w_err      = 1'b1;
                    w_err_code = 3'd2;
                end else begin
                    w_addr_nxt  = cell_idx(i_hum_row, i_hum_col);
                    w_is_ai_nxt = 1'b0;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                if (i_brd_rd_data != 2'b00) begin
                    w_err       = 1'b1;
                    w_err_code  = 3'd3;
                    w_state_nxt = r_is_ai ? AI_START : IDLE;
                end else begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE:     w_state_nxt = CHK_START;
            CHK_START: w_state_nxt = CHK_WAIT;
            CHK_WAIT: begin
                if (!i_chk_done) begin
                    w_state_nxt = CHK_WAIT;
                end else if (i_chk_win != 2'b00) begin
                    w_win_nxt       = i_chk_win;
                    w_game_over_nxt = 1'b1;
                    w_state_nxt     = OVER;
                end else begin
                    // ai_en is only consulted here, when the turn passes
                    w_turn_nxt  = w_turn_tog;
                    w_o_ai_nxt  = (w_turn_tog == P_O) && i_ai_en;
                    w_state_nxt = w_o_ai_nxt ? AI_START : IDLE;
                end
            end
            AI_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = AI_WAIT;
            end
            AI_WAIT: begin
                if (i_ai_done) begin
                    if (i_ai_row == 2'd3 || i_ai_col == 2'd3) begin
                        w_err       = 1'b1;
                        w_err_code  = 3'd1;
                        w_state_nxt = AI_START;
                    end else begin
                        w_addr_nxt  = cell_idx(i_ai_row, i_ai_col);
                        w_is_ai_nxt = 1'b1;
                        w_state_nxt = READ;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_err       = 1'b1;
                    w_err_code  = 3'd5;
                    w_o_ai_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            OVER: begin
                if (w_accept) begin
                    w_err      = 1'b1;
                    w_err_code = 3'd4;
                end else begin
                    w_err = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_turn      <= P_X;
            r_o_ai      <= 1'b0;
            r_is_ai     <= 1'b0;
            r_cnt       <= '0;
            r_addr      <= 4'd0;
            r_err       <= 1'b0;
            r_err_code  <= 3'd0;
            r_game_over <= 1'b0;
            r_win       <= 2'b00;
            r_hum_ready <= 1'b1;
            r_ai_start  <= 1'b0;
            r_brd_we    <= 1'b0;
            r_brd_wdata <= 2'b00;
            r_chk_start <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_turn      <= w_turn_nxt;
            r_o_ai      <= w_o_ai_nxt;
            r_is_ai     <= w_is_ai_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_err       <= w_err;
            r_err_code  <= w_err_code;
            r_game_over <= w_game_over_nxt;
            r_win       <= w_win_nxt;
            r_hum_ready <= (w_state_nxt == IDLE && (w_turn_nxt == P_X || !w_o_ai_nxt)) ||
                           (w_state_nxt == OVER);
            r_ai_start  <= (w_state_nxt == AI_START);
            r_brd_we    <= (w_state_nxt == WRITE);
            r_brd_wdata <= (w_state_nxt == WRITE) ? w_turn_nxt : 2'b00;
            r_chk_start <= (w_state_nxt == CHK_START);
        end
    end

    assign o_hum_ready = r_hum_ready;
    assign o_ai_start  = r_ai_start;
    assign o_brd_addr  = r_addr;
    assign o_brd_we    = r_brd_we;
    assign o_brd_wdata = r_brd_wdata;
    assign o_chk_start = r_chk_start;
    assign o_turn      = r_turn;
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;
    assign o_game_over = r_game_over;
    assign o_win       = r_win;

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: a board model answers reads, and
// scoreboard queues hold the board writes and error codes each scenario expects.
module tb_move_scheduler;

    localparam int AI_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_ai_en = 1'b0;
    logic       i_hum_valid = 1'b0;
    logic [1:0] i_hum_player = 2'b00, i_hum_row = 2'b00, i_hum_col = 2'b00;
    logic       i_ai_done = 1'b0;
    logic [1:0] i_ai_row = 2'b00, i_ai_col = 2'b00;
    logic [1:0] i_brd_rd_data;
    logic       i_chk_done = 1'b0;
    logic [1:0] i_chk_win = 2'b00;
    logic       o_hum_ready, o_ai_start, o_brd_we, o_chk_start, o_err, o_game_over;
    logic [3:0] o_brd_addr;
    logic [1:0] o_brd_wdata, o_turn, o_win;
    logic [2:0] o_err_code;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] board [16];
    logic [5:0] exp_wr_q [$];
    logic [2:0] exp_err_q [$];

    move_scheduler #(.AI_TIMEOUT(AI_TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .i_ai_en(i_ai_en),
        .i_hum_valid(i_hum_valid), .o_hum_ready(o_hum_ready),
        .i_hum_player(i_hum_player), .i_hum_row(i_hum_row), .i_hum_col(i_hum_col),
        .o_ai_start(o_ai_start), .i_ai_done(i_ai_done), .i_ai_row(i_ai_row), .i_ai_col(i_ai_col),
        .o_brd_addr(o_brd_addr), .i_brd_rd_data(i_brd_rd_data),
        .o_brd_we(o_brd_we), .o_brd_wdata(o_brd_wdata),
        .o_chk_start(o_chk_start), .i_chk_done(i_chk_done), .i_chk_win(i_chk_win),
        .o_turn(o_turn), .o_err(o_err), .o_err_code(o_err_code),
        .o_game_over(o_game_over), .o_win(o_win)
    );

    always #5 clk = ~clk;

    always_comb i_brd_rd_data = board[o_brd_addr];

    always @(posedge clk) begin
        if (!reset && o_brd_we) board[o_brd_addr] <= o_brd_wdata;
    end

    // Scoreboard: every write and error pulse must match the next expected entry
    always @(negedge clk) begin
        if (o_brd_we) begin
            vectors++;
            if (exp_wr_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write got addr=%0d data=%b expected none", o_brd_addr, o_brd_wdata);
            end else begin
                logic [5:0] e;
                e = exp_wr_q.pop_front();
                if ({o_brd_addr, o_brd_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL board_write got addr=%0d data=%b expected addr=%0d data=%b",
                             o_brd_addr, o_brd_wdata, e[5:2], e[1:0]);
                end
            end
        end
        if (o_err) begin
            vectors++;
            if (exp_err_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_err got code=%0d expected no error", o_err_code);
            end else begin
                logic [2:0] c;
                c = exp_err_q.pop_front();
                if (o_err_code !== c) begin
                    miscompares++;
                    $display("FAIL err_code got %0d expected %0d", o_err_code, c);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_hum_valid = 1'b0;
        i_ai_done = 1'b0;
        i_chk_done = 1'b0;
        for (int i = 0; i < 16; i++) board[i] = 2'b00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic human_move(input logic [1:0] p, input logic [1:0] r, input logic [1:0] c);
        int n = 0;
        while (!o_hum_ready && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (!o_hum_ready) begin
            miscompares++;
            $display("FAIL hum_ready_wait got 0 expected 1");
        end
        i_hum_valid = 1'b1;
        i_hum_player = p;
        i_hum_row = r;
        i_hum_col = c;
        tick();
        i_hum_valid = 1'b0;
    endtask

    task automatic run_check(input logic [1:0] w);
        int n = 0;
        while (!o_chk_start && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (!o_chk_start) begin
            miscompares++;
            $display("FAIL chk_start_wait got 0 expected 1");
        end
        tick();
        i_chk_done = 1'b1;
        i_chk_win = w;
        tick();
        i_chk_done = 1'b0;
        i_chk_win = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({o_turn, o_game_over, o_win, o_err, o_err_code} !== {2'b01, 1'b0, 2'b00, 1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL reset_status got turn=%b go=%b win=%b err=%b code=%0d expected 01 0 00 0 0",
                     o_turn, o_game_over, o_win, o_err, o_err_code);
        end
        vectors++;
        if ({o_ai_start, o_brd_we, o_chk_start, o_brd_addr, o_hum_ready} !== {1'b0, 1'b0, 1'b0, 4'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_strobes got ai=%b we=%b chk=%b addr=%0d rdy=%b expected 0 0 0 0 1",
                     o_ai_start, o_brd_we, o_chk_start, o_brd_addr, o_hum_ready);
        end
    endtask

    task automatic test_x_move();
        do_reset();
        exp_wr_q.push_back({4'd0, 2'b01});
        human_move(2'b01, 2'd0, 2'd0);
        vectors++;
        if ({o_brd_we, o_brd_addr, o_hum_ready} !== {1'b0, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL read_cycle got we=%b addr=%0d rdy=%b expected 0 0 0", o_brd_we, o_brd_addr, o_hum_ready);
        end
        tick();
        vectors++;
        if ({o_brd_we, o_brd_wdata, o_chk_start} !== {1'b1, 2'b01, 1'b0}) begin
            miscompares++;
            $display("FAIL write_cycle got we=%b data=%b chk=%b expected 1 01 0", o_brd_we, o_brd_wdata, o_chk_start);
        end
        tick();
        vectors++;
        if ({o_brd_we, o_chk_start} !== 2'b01) begin
            miscompares++;
            $display("FAIL chk_start_cycle got we=%b chk=%b expected 0 1", o_brd_we, o_chk_start);
        end
        tick();
        i_chk_done = 1'b1;
        tick();
        i_chk_done = 1'b0;
        vectors++;
        if ({o_turn, o_hum_ready, o_chk_start} !== {2'b10, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL turn_toggle got turn=%b rdy=%b chk=%b expected 10 1 0", o_turn, o_hum_ready, o_chk_start);
        end
    endtask

    task automatic test_bad_moves();
        do_reset();
        exp_err_q.push_back(3'd2);
        human_move(2'b10, 2'd0, 2'd0);
        vectors++;
        if ({o_err, o_err_code, o_turn, o_hum_ready} !== {1'b1, 3'd2, 2'b01, 1'b1}) begin
            miscompares++;
            $display("FAIL wrong_turn got err=%b code=%0d turn=%b rdy=%b expected 1 2 01 1",
                     o_err, o_err_code, o_turn, o_hum_ready);
        end
        tick();
        vectors++;
        if ({o_err, o_err_code} !== {1'b0, 3'd2}) begin
            miscompares++;
            $display("FAIL err_hold got err=%b code=%0d expected 0 2", o_err, o_err_code);
        end
        exp_err_q.push_back(3'd1);
        human_move(2'b01, 2'd3, 2'd0);
        vectors++;
        if ({o_err, o_err_code} !== {1'b1, 3'd1}) begin
            miscompares++;
            $display("FAIL bad_row got err=%b code=%0d expected 1 1", o_err, o_err_code);
        end
        exp_err_q.push_back(3'd1);
        human_move(2'b11, 2'd0, 2'd0);
        tick();
    endtask

    task automatic test_occupied();
        do_reset();
        board[4] = 2'b01;
        exp_err_q.push_back(3'd3);
        human_move(2'b01, 2'd1, 2'd1);
        i_hum_valid = 1'b1;
        i_hum_player = 2'b11;
        vectors++;
        if ({o_brd_addr, o_hum_ready} !== {4'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL occ_read got addr=%0d rdy=%b expected 4 0", o_brd_addr, o_hum_ready);
        end
        tick();
        i_hum_valid = 1'b0;
        vectors++;
        if ({o_err, o_err_code, o_hum_ready, o_turn} !== {1'b1, 3'd3, 1'b1, 2'b01}) begin
            miscompares++;
            $display("FAIL occupied got err=%b code=%0d rdy=%b turn=%b expected 1 3 1 01",
                     o_err, o_err_code, o_hum_ready, o_turn);
        end
        tick();
    endtask

    task automatic test_ai_move();
        do_reset();
        i_ai_en = 1'b1;
        exp_wr_q.push_back({4'd0, 2'b01});
        human_move(2'b01, 2'd0, 2'd0);
        run_check(2'b00);
        vectors++;
        if ({o_ai_start, o_turn, o_hum_ready} !== {1'b1, 2'b10, 1'b0}) begin
            miscompares++;
            $display("FAIL ai_start got ai=%b turn=%b rdy=%b expected 1 10 0", o_ai_start, o_turn, o_hum_ready);
        end
        tick();
        vectors++;
        if (o_ai_start !== 1'b0) begin
            miscompares++;
            $display("FAIL ai_start_pulse got %b expected 0", o_ai_start);
        end
        exp_err_q.push_back(3'd1);
        i_ai_done = 1'b1;
        i_ai_row = 2'd3;
        i_ai_col = 2'd0;
        tick();
        i_ai_done = 1'b0;
        vectors++;
        if ({o_err, o_err_code, o_ai_start} !== {1'b1, 3'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL ai_bad_coord got err=%b code=%0d ai=%b expected 1 1 1", o_err, o_err_code, o_ai_start);
        end
        for (int i = 0; i < 4; i++) tick();
        exp_wr_q.push_back({4'd8, 2'b10});
        i_ai_done = 1'b1;
        i_ai_row = 2'd2;
        i_ai_col = 2'd2;
        tick();
        i_ai_done = 1'b0;
        vectors++;
        if ({o_brd_addr, o_brd_we} !== {4'd8, 1'b0}) begin
            miscompares++;
            $display("FAIL ai_read got addr=%0d we=%b expected 8 0", o_brd_addr, o_brd_we);
        end
        run_check(2'b00);
        vectors++;
        if ({o_turn, o_hum_ready, o_ai_start} !== {2'b01, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL ai_done_turn got turn=%b rdy=%b ai=%b expected 01 1 0", o_turn, o_hum_ready, o_ai_start);
        end
    endtask

    task automatic test_ai_timeout();
        int n = 0;
        do_reset();
        i_ai_en = 1'b1;
        exp_wr_q.push_back({4'd0, 2'b01});
        human_move(2'b01, 2'd0, 2'd0);
        run_check(2'b00);
        exp_err_q.push_back(3'd5);
        while (!o_err && n < 40) begin
            tick();
            n++;
            if (n == 3) i_ai_en = 1'b0;
        end
        vectors++;
        if (n !== AI_TIMEOUT + 1) begin
            miscompares++;
            $display("FAIL ai_timeout_latency got %0d expected %0d", n, AI_TIMEOUT + 1);
        end
        vectors++;
        if ({o_err_code, o_hum_ready, o_turn} !== {3'd5, 1'b1, 2'b10}) begin
            miscompares++;
            $display("FAIL ai_timeout got code=%0d rdy=%b turn=%b expected 5 1 10", o_err_code, o_hum_ready, o_turn);
        end
        i_ai_en = 1'b1;
        exp_wr_q.push_back({4'd1, 2'b10});
        human_move(2'b10, 2'd0, 2'd1);
        run_check(2'b00);
        vectors++;
        if (o_turn !== 2'b01) begin
            miscompares++;
            $display("FAIL fallback_turn got %b expected 01", o_turn);
        end
        i_ai_en = 1'b0;
    endtask

    task automatic test_game_over();
        logic [1:0] mv [5][3];
        mv = '{'{2'b01, 2'd0, 2'd0}, '{2'b10, 2'd1, 2'd0}, '{2'b01, 2'd0, 2'd1},
               '{2'b10, 2'd1, 2'd1}, '{2'b01, 2'd0, 2'd2}};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_wr_q.push_back({{2'b00, mv[i][1]} * 4'd3 + {2'b00, mv[i][2]}, mv[i][0]});
            human_move(mv[i][0], mv[i][1], mv[i][2]);
            run_check((i == 4) ? 2'b01 : 2'b00);
        end
        vectors++;
        if ({o_game_over, o_win, o_hum_ready} !== {1'b1, 2'b01, 1'b1}) begin
            miscompares++;
            $display("FAIL game_over got go=%b win=%b rdy=%b expected 1 01 1", o_game_over, o_win, o_hum_ready);
        end
        exp_err_q.push_back(3'd4);
        human_move(2'b10, 2'd2, 2'd2);
        vectors++;
        if ({o_err, o_err_code, o_game_over} !== {1'b1, 3'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL over_move got err=%b code=%0d go=%b expected 1 4 1", o_err, o_err_code, o_game_over);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        human_move(2'b01, 2'd2, 2'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({o_brd_we, o_turn, o_hum_ready} !== {1'b0, 2'b01, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_in_read got we=%b turn=%b rdy=%b expected 0 01 1", o_brd_we, o_turn, o_hum_ready);
        end
        tick();
        exp_wr_q.push_back({4'd4, 2'b01});
        human_move(2'b01, 2'd1, 2'd1);
        while (!o_chk_start) tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({o_turn, o_game_over, o_win, o_hum_ready, o_chk_start} !== {2'b01, 1'b0, 2'b00, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_in_chk_wait got turn=%b go=%b win=%b rdy=%b chk=%b expected 01 0 00 1 0",
                     o_turn, o_game_over, o_win, o_hum_ready, o_chk_start);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) board[i] = 2'b00;
        test_reset();
        test_x_move();
        test_bad_moves();
        test_occupied();
        test_ai_move();
        test_ai_timeout();
        test_game_over();
        test_reset_mid();
        tick();
        tick();
        vectors++;
        if (exp_wr_q.size() != 0 || exp_err_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got wr=%0d err=%0d pending expected 0 0",
                     exp_wr_q.size(), exp_err_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
